// File: rtl/gs232c_bp_pkg.sv
// Shared branch-predictor defaults and the global-history shift rule.
// The shift function is sized for the widest supported history and slot count; callers cast in and out.
package gs232c_bp_pkg;

   localparam int HLEN_DEF  = 24;
   localparam int NSLOT_DEF = 4;
   localparam int NCKPT_DEF = 8;

   localparam int HMAX = 64;
   localparam int SMAX = 16;

   // Each branch slot shifts in its direction; scanning stops after the first taken branch.
   function automatic logic [HMAX-1:0] ghr_shift(input logic [HMAX-1:0] hist,
                                                 input logic [SMAX-1:0] brop,
                                                 input logic [SMAX-1:0] taken);
      logic [HMAX-1:0] h;
      logic            stop;
      h    = hist;
      stop = 1'b0;
      for (int i = 0; i < SMAX; i++) begin
         if (!stop && brop[i]) begin
            h    = {h[HMAX-2:0], taken[i]};
            stop = taken[i];
         end
      end
      return h;
   endfunction

endpackage

// File: rtl/gs232c_hr_shift.sv
// Applies the shift rule for one fetch/commit group to an HLEN-bit history.
module gs232c_hr_shift
   import gs232c_bp_pkg::*;
#(
   parameter int HLEN  = HLEN_DEF,
   parameter int NSLOT = NSLOT_DEF
) (
   input  logic [HLEN-1:0]  hist_i,
   input  logic [NSLOT-1:0] brop_i,
   input  logic [NSLOT-1:0] taken_i,
   output logic [HLEN-1:0]  hist_o
);

   assign hist_o = HLEN'(ghr_shift(HMAX'(hist_i), SMAX'(brop_i), SMAX'(taken_i)));

endmodule

// File: rtl/gs232c_ghr_ckpt.sv
// Speculative/committed global history with a circular checkpoint queue for
// redirect recovery; flush restores from the committed history.
module gs232c_ghr_ckpt
   import gs232c_bp_pkg::*;
#(
   parameter int  HLEN  = HLEN_DEF,
   parameter int  NSLOT = NSLOT_DEF,
   parameter int  NCKPT = NCKPT_DEF,
   localparam int TAGW  = $clog2(NCKPT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fe_valid,
   input  logic [NSLOT-1:0] fe_brop,
   input  logic [NSLOT-1:0] fe_taken,
   output logic             fe_ready,
   output logic [TAGW-1:0]  fe_tag,
   input  logic             rd_valid,
   input  logic [TAGW-1:0]  rd_tag,
   input  logic [NSLOT-1:0] rd_brop,
   input  logic [NSLOT-1:0] rd_taken,
   input  logic             cm_valid,
   input  logic [NSLOT-1:0] cm_brop,
   input  logic [NSLOT-1:0] cm_taken,
   input  logic             fl_valid,
   output logic [HLEN-1:0]  hr_pred,
   output logic [HLEN-1:0]  hr_arch,
   output logic [TAGW:0]    ck_count
);

   logic [HLEN-1:0] ckpt_q [NCKPT];
   logic [HLEN-1:0] hpred_q, hpred_d;
   logic [HLEN-1:0] harch_q, harch_d;
   logic [TAGW-1:0] head_q, head_d;
   logic [TAGW-1:0] tail_q, tail_d;
   logic [TAGW:0]   cnt_q, cnt_d;
   logic [TAGW-1:0] rd_span;
   logic [HLEN-1:0] fe_hist, rd_hist, cm_hist;
   logic            fe_alloc, cm_free;

   gs232c_hr_shift #(.HLEN(HLEN), .NSLOT(NSLOT)) u_fe_shift (
      .hist_i(hpred_q), .brop_i(fe_brop), .taken_i(fe_taken), .hist_o(fe_hist));

   gs232c_hr_shift #(.HLEN(HLEN), .NSLOT(NSLOT)) u_rd_shift (
      .hist_i(ckpt_q[rd_tag]), .brop_i(rd_brop), .taken_i(rd_taken), .hist_o(rd_hist));

   gs232c_hr_shift #(.HLEN(HLEN), .NSLOT(NSLOT)) u_cm_shift (
      .hist_i(harch_q), .brop_i(cm_brop), .taken_i(cm_taken), .hist_o(cm_hist));

   assign fe_ready = (cnt_q < (TAGW+1)'(NCKPT)) && !rd_valid && !fl_valid;
   assign fe_tag   = tail_q;
   assign fe_alloc = fe_valid && fe_ready && (|fe_brop);
   assign cm_free  = cm_valid && (|cm_brop);

   always_comb begin
      harch_d = cm_valid ? cm_hist : harch_q;
      head_d  = head_q + TAGW'(cm_free);
      hpred_d = hpred_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q - (TAGW+1)'(cm_free);
      rd_span = '0;
      if (fl_valid) begin
         hpred_d = harch_d;
         tail_d  = head_d;
         cnt_d   = '0;
      end else if (rd_valid) begin
         hpred_d = rd_hist;
         tail_d  = rd_tag + TAGW'(1);
         // The redirected entry survives, so a zero pointer distance means the queue is full.
         rd_span = tail_d - head_d;
         cnt_d   = (rd_span == '0) ? (TAGW+1)'(NCKPT) : {1'b0, rd_span};
      end else if (fe_alloc) begin
         hpred_d = fe_hist;
         tail_d  = tail_q + TAGW'(1);
         cnt_d   = cnt_q + (TAGW+1)'(1) - (TAGW+1)'(cm_free);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hpred_q <= '0;
         harch_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         hpred_q <= hpred_d;
         harch_q <= harch_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (fe_alloc) ckpt_q[tail_q] <= hpred_q;
   end

   assign hr_pred  = hpred_q;
   assign hr_arch  = harch_q;
   assign ck_count = cnt_q;

endmodule

// File: tb/tb_gs232c_ghr_ckpt.sv
// Bench for gs232c_ghr_ckpt: directed vector table, multi-cycle corner sequences,
// and a randomized run against a queue-based reference model.
module tb_gs232c_ghr_ckpt;

   localparam int HLEN = 24;
   localparam int NSLOT = 4;
   localparam int NCKPT = 8;
   localparam int TAGW = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic             fe_valid;
   logic [NSLOT-1:0] fe_brop, fe_taken;
   logic             fe_ready;
   logic [TAGW-1:0]  fe_tag;
   logic             rd_valid;
   logic [TAGW-1:0]  rd_tag;
   logic [NSLOT-1:0] rd_brop, rd_taken;
   logic             cm_valid;
   logic [NSLOT-1:0] cm_brop, cm_taken;
   logic             fl_valid;
   logic [HLEN-1:0]  hr_pred, hr_arch;
   logic [TAGW:0]    ck_count;

   int checks = 0;
   int errors = 0;

   gs232c_ghr_ckpt #(.HLEN(HLEN), .NSLOT(NSLOT), .NCKPT(NCKPT)) dut (
      .clock(clock), .reset(reset),
      .fe_valid(fe_valid), .fe_brop(fe_brop), .fe_taken(fe_taken),
      .fe_ready(fe_ready), .fe_tag(fe_tag),
      .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_brop(rd_brop), .rd_taken(rd_taken),
      .cm_valid(cm_valid), .cm_brop(cm_brop), .cm_taken(cm_taken),
      .fl_valid(fl_valid),
      .hr_pred(hr_pred), .hr_arch(hr_arch), .ck_count(ck_count));

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] brop;
      logic [3:0] taken;
      int         exp_pred;
      int         exp_cnt;
      int         exp_tag;
   } vec_t;

   typedef struct {
      int tag;
      int h;
   } ent_t;

   vec_t vecs[6];
   ent_t mq[$];
   int   m_next, m_head, m_pred, m_arch;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference shift rule: history as an integer modulo 2^HLEN.
   function automatic int mshift(input int h, input logic [3:0] b, input logic [3:0] t);
      int r = h;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) begin
            r = (r * 2 + int'(t[i])) % (1 << HLEN);
            if (t[i]) break;
         end
      end
      return r;
   endfunction

   task automatic idle();
      fe_valid = 0; fe_brop = 0; fe_taken = 0;
      rd_valid = 0; rd_tag = 0; rd_brop = 0; rd_taken = 0;
      cm_valid = 0; cm_brop = 0; cm_taken = 0;
      fl_valid = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 0;
   endtask

   task automatic fetch(input logic [3:0] b, input logic [3:0] t);
      idle();
      fe_valid = 1; fe_brop = b; fe_taken = t;
      tick();
   endtask

   initial begin
      reset = 1;
      idle();
      vecs[0] = '{4'b0011, 4'b0010, 'h001, 1, 0};
      vecs[1] = '{4'b1111, 4'b0000, 'h010, 2, 1};
      vecs[2] = '{4'b0101, 4'b0100, 'h041, 3, 2};
      vecs[3] = '{4'b0000, 4'b0000, 'h041, 3, -1};
      vecs[4] = '{4'b1010, 4'b1000, 'h105, 4, 3};
      vecs[5] = '{4'b1111, 4'b0001, 'h20B, 5, 4};

      do_reset();
      chk("reset_pred", hr_pred, 0);
      chk("reset_arch", hr_arch, 0);
      chk("reset_count", ck_count, 0);
      chk("reset_ready", fe_ready, 1);
      chk("reset_tag", fe_tag, 0);

      // Directed fetch vectors
      for (int i = 0; i < 6; i++) begin
         idle();
         fe_valid = 1; fe_brop = vecs[i].brop; fe_taken = vecs[i].taken;
         #1;
         chk($sformatf("vec%0d_ready", i), fe_ready, 1);
         if (vecs[i].exp_tag >= 0) chk($sformatf("vec%0d_tag", i), fe_tag, vecs[i].exp_tag);
         tick();
         chk($sformatf("vec%0d_pred", i), hr_pred, vecs[i].exp_pred);
         chk($sformatf("vec%0d_count", i), ck_count, vecs[i].exp_cnt);
      end
      // Checkpoint 0 held the pre-update history (0); redirect to it with no branches
      idle();
      rd_valid = 1; rd_tag = 0;
      tick();
      chk("ckpt0_pred", hr_pred, 0);
      chk("ckpt0_count", ck_count, 1);

      // Fill to full, then commit one
      do_reset();
      for (int i = 0; i < 9; i++) begin
         idle();
         fe_valid = 1; fe_brop = 4'b0001;
         #1;
         chk($sformatf("fill%0d_ready", i), fe_ready, (i < 8) ? 1 : 0);
         if (i < 8) chk($sformatf("fill%0d_tag", i), fe_tag, i);
         tick();
      end
      chk("full_count", ck_count, 8);
      cm_valid = 1; cm_brop = 4'b0001; cm_taken = 0;
      #1;
      chk("full_commit_ready", fe_ready, 0);
      tick();
      chk("after_commit_count", ck_count, 7);
      idle();
      fe_valid = 1; fe_brop = 4'b0001;
      #1;
      chk("after_commit_ready", fe_ready, 1);
      chk("wrap_tag", fe_tag, 0);
      tick();
      chk("refill_count", ck_count, 8);

      // Redirect to tag 1 with four live
      do_reset();
      for (int i = 0; i < 4; i++) fetch(4'b0001, 4'b0001);
      chk("rd_pre_pred", hr_pred, 'hF);
      idle();
      fe_valid = 1; fe_brop = 4'b0001;
      rd_valid = 1; rd_tag = 1; rd_brop = 4'b0001; rd_taken = 4'b0001;
      #1;
      chk("rd_ready", fe_ready, 0);
      tick();
      chk("rd_pred", hr_pred, 3);
      chk("rd_count", ck_count, 2);
      idle();
      fe_valid = 1; fe_brop = 4'b0001;
      #1;
      chk("rd_tail_tag", fe_tag, 2);
      tick();
      chk("rd_next_pred", hr_pred, 6);
      chk("rd_next_count", ck_count, 3);

      // Flush with simultaneous commit
      do_reset();
      fetch(4'b0001, 4'b0000);
      chk("fl_pre_count", ck_count, 1);
      idle();
      fl_valid = 1; cm_valid = 1; cm_brop = 4'b0001; cm_taken = 4'b0001;
      tick();
      chk("fl_arch", hr_arch, 1);
      chk("fl_pred", hr_pred, 1);
      chk("fl_count", ck_count, 0);

      // Fetch + redirect + flush together
      idle();
      fe_valid = 1; fe_brop = 4'b0001; fe_taken = 4'b0001;
      #1;
      chk("post_fl_tag", fe_tag, 1);
      tick();
      chk("combo_pre_pred", hr_pred, 3);
      idle();
      fe_valid = 1; fe_brop = 4'b0001; fe_taken = 4'b0001;
      rd_valid = 1; rd_tag = 1; rd_brop = 4'b0001; rd_taken = 4'b0001;
      fl_valid = 1;
      #1;
      chk("combo_ready", fe_ready, 0);
      tick();
      chk("combo_pred", hr_pred, 1);
      chk("combo_count", ck_count, 0);
      chk("combo_arch", hr_arch, 1);
      idle();
      #1;
      chk("combo_tag", fe_tag, 1);

      // Asynchronous reset mid-cycle
      do_reset();
      for (int i = 0; i < 5; i++) fetch(4'b0001, 4'b0001);
      chk("ar_pre_count", ck_count, 5);
      chk("ar_pre_pred", hr_pred, 'h1F);
      idle();
      #2 reset = 1;
      #1;
      chk("ar_pred", hr_pred, 0);
      chk("ar_arch", hr_arch, 0);
      chk("ar_count", ck_count, 0);
      chk("ar_tag", fe_tag, 0);
      @(posedge clock);
      #1 reset = 0;
      #1;
      chk("ar_ready", fe_ready, 1);

      // Randomized run against the reference model
      do_reset();
      mq.delete();
      m_next = 0; m_head = 0; m_pred = 0; m_arch = 0;
      for (int c = 0; c < 600; c++) begin
         int  idx;
         int  rd_h;
         bit  freed, exp_ready, alloc;
         idle();
         fe_valid = ($urandom_range(0, 3) != 0);
         fe_brop  = 4'($urandom);
         fe_taken = 4'($urandom);
         cm_taken = 4'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            cm_valid = 1;
            cm_brop  = (mq.size() > 0) ? 4'($urandom) : 4'b0;
         end
         freed = cm_valid && (cm_brop != 0);
         rd_brop  = 4'($urandom);
         rd_taken = 4'($urandom);
         idx = 0;
         if ($urandom_range(0, 9) == 0 && mq.size() > int'(freed)) begin
            rd_valid = 1;
            idx = $urandom_range(int'(freed), mq.size() - 1);
            rd_tag = TAGW'(mq[idx].tag);
         end
         fl_valid = ($urandom_range(0, 39) == 0);
         exp_ready = (mq.size() < NCKPT) && !rd_valid && !fl_valid;
         alloc = fe_valid && exp_ready && (fe_brop != 0);
         #1;
         chk("rnd_ready", fe_ready, exp_ready);
         if (alloc) chk("rnd_tag", fe_tag, m_next);

         rd_h = rd_valid ? mshift(mq[idx].h, rd_brop, rd_taken) : 0;
         if (cm_valid) m_arch = mshift(m_arch, cm_brop, cm_taken);
         if (freed) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % NCKPT;
         end
         if (fl_valid) begin
            mq.delete();
            m_next = m_head;
            m_pred = m_arch;
         end else if (rd_valid) begin
            while (mq.size() > idx + 1 - int'(freed)) void'(mq.pop_back());
            m_next = (int'(rd_tag) + 1) % NCKPT;
            m_pred = rd_h;
         end else if (alloc) begin
            mq.push_back('{m_next, m_pred});
            m_next = (m_next + 1) % NCKPT;
            m_pred = mshift(m_pred, fe_brop, fe_taken);
         end
         tick();
         chk("rnd_pred", hr_pred, m_pred);
         chk("rnd_arch", hr_arch, m_arch);
         chk("rnd_count", ck_count, mq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
